// File: rtl/jtframe_sdram_pkg.sv
// Shared types for the SDRAM bank arbiter: FSM states and SDRAM bank-select width.
package jtframe_sdram_pkg;

   localparam int BA_W = 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   // Width of a channel index; a single channel still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/jtframe_bank_arb_if.sv
// Command bus between the bank arbiter (master) and the single-command SDRAM controller (slave).
interface jtframe_bank_arb_if
   import jtframe_sdram_pkg::*;
#(
   parameter int AW = 22
) ();
   logic [AW-1:0]   addr;
   logic [BA_W-1:0] ba;
   logic [15:0]     din;
   logic [1:0]      din_m;
   logic            rd;
   logic            wr;
   logic            rfsh;
   logic            ack;
   logic            rdy;

   modport master (output addr, ba, din, din_m, rd, wr, rfsh, input ack, rdy);
   modport slave  (input addr, ba, din, din_m, rd, wr, rfsh, output ack, rdy);
endinterface

// File: rtl/jtframe_rr_pick.sv
// Rotating-priority picker: first set bit of req at or after start (wrapping) wins.
module jtframe_rr_pick
   import jtframe_sdram_pkg::*;
#(
   parameter int BANKS = 4,
   parameter int IW    = 2
) (
   input  logic [BANKS-1:0] req,
   input  logic [IW-1:0]    start,
   output logic [BANKS-1:0] grant,
   output logic [IW-1:0]    idx,
   output logic             any
);

   always_comb begin
      int j;
      // NOTE: every output gets a default before the loop so no path leaves a latch behind.
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = 0; k < BANKS; k++) begin
         j = (int'(start) + k) % BANKS;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/jtframe_bank_arb.sv
// SDRAM request arbiter: BANKS game channels plus the download port onto one controller.
// Define JTFRAME_BA_FIXPRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module jtframe_bank_arb
   import jtframe_sdram_pkg::*;
#(
   parameter int               BANKS   = 4,
   parameter int               AW      = 22,
   parameter logic [BANKS-1:0] WR_MASK = BANKS'(1)
) (
   input  logic                 clk_rom,
   input  logic                 rst,
   input  logic                 downloading,
   input  logic [AW-1:0]        prog_addr,
   input  logic [BA_W-1:0]      prog_ba,
   input  logic [15:0]          prog_data,
   input  logic [1:0]           prog_mask,
   input  logic                 prog_we,
   input  logic                 prog_rd,
   output logic                 prog_ack,
   output logic                 prog_rdy,
   input  logic [BANKS*AW-1:0]  ba_addr,
   input  logic [BANKS-1:0]     ba_rd,
   input  logic [BANKS-1:0]     ba_wr,
   input  logic [BANKS*16-1:0]  ba_din,
   input  logic [BANKS*2-1:0]   ba_din_m,
   output logic [BANKS-1:0]     ba_ack,
   output logic [BANKS-1:0]     ba_rdy,
   input  logic                 rfsh_en,
   jtframe_bank_arb_if.master   ctl
);

   localparam int IW = idx_w(BANKS);

   state_t          state;
   logic            own_prog;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   start;
   logic [IW-1:0]   win_idx;
   logic [BANKS-1:0] req;
   logic [BANKS-1:0] win_oh;
   logic            win_any;
   logic            wr_ok;
   logic            prog_req;

   logic [AW-1:0]   addr_r;
   logic [BA_W-1:0] ba_r;
   logic [15:0]     din_r;
   logic [1:0]      din_m_r;
   logic            rd_r;
   logic            wr_r;
   logic            rfsh_r;

   // Writes on banks without permission are invisible, so a write-only request there never competes.
   assign req      = downloading ? '0 : (ba_rd | (ba_wr & WR_MASK));
   assign prog_req = prog_we | prog_rd;
   assign wr_ok    = |(win_oh & ba_wr & WR_MASK);

   jtframe_rr_pick #(
      .BANKS (BANKS),
      .IW    (IW)
   ) u_pick (
      .req   (req),
      .start (start),
      .grant (win_oh),
      .idx   (win_idx),
      .any   (win_any)
   );

`ifdef JTFRAME_BA_FIXPRIO_EN
   assign start = '0;
`else
   logic [IW-1:0] rr_ptr;
   logic          fin;

   assign fin = ((state == ISSUE) && ctl.ack && ctl.rdy) || ((state == WAIT) && ctl.rdy);

   always_ff @(posedge clk_rom) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (fin && !own_prog) begin
         rr_ptr <= (owner == IW'(BANKS-1)) ? '0 : owner + IW'(1);
      end
   end

   assign start = rr_ptr;
`endif

   always_ff @(posedge clk_rom) begin
      // NOTE: state registers use non-blocking assignments so every read in this block sees the pre-edge value.
      if (rst) begin
         state    <= IDLE;
         own_prog <= 1'b0;
         owner    <= '0;
         addr_r   <= '0;
         ba_r     <= '0;
         din_r    <= '0;
         din_m_r  <= '0;
         rd_r     <= 1'b0;
         wr_r     <= 1'b0;
         rfsh_r   <= 1'b0;
         ba_ack   <= '0;
         ba_rdy   <= '0;
         prog_ack <= 1'b0;
         prog_rdy <= 1'b0;
      end else begin
         ba_ack   <= '0;
         ba_rdy   <= '0;
         prog_ack <= 1'b0;
         prog_rdy <= 1'b0;
         rfsh_r   <= 1'b0;
         case (state)
            IDLE: begin
               if (downloading && prog_req) begin
                  own_prog <= 1'b1;
                  addr_r   <= prog_addr;
                  ba_r     <= prog_ba;
                  din_r    <= prog_data;
                  din_m_r  <= prog_mask;
                  wr_r     <= prog_we;
                  rd_r     <= prog_rd & ~prog_we;
                  state    <= ISSUE;
               end else if (win_any) begin
                  own_prog <= 1'b0;
                  owner    <= win_idx;
                  addr_r   <= ba_addr[win_idx*AW +: AW];
                  ba_r     <= BA_W'(win_idx);
                  din_r    <= ba_din[win_idx*16 +: 16];
                  din_m_r  <= ba_din_m[win_idx*2 +: 2];
                  wr_r     <= wr_ok;
                  rd_r     <= ~wr_ok;
                  state    <= ISSUE;
               end else if (rfsh_en && !rfsh_r) begin
                  rfsh_r <= 1'b1;
               end
            end
            ISSUE: begin
               if (ctl.ack) begin
                  rd_r <= 1'b0;
                  wr_r <= 1'b0;
                  if (own_prog) prog_ack <= 1'b1;
                  else          ba_ack[owner] <= 1'b1;
                  if (ctl.rdy) begin
                     if (own_prog) prog_rdy <= 1'b1;
                     else          ba_rdy[owner] <= 1'b1;
                     state <= IDLE;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (ctl.rdy) begin
                  if (own_prog) prog_rdy <= 1'b1;
                  else          ba_rdy[owner] <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ctl.addr  = addr_r;
   assign ctl.ba    = ba_r;
   assign ctl.din   = din_r;
   assign ctl.din_m = din_m_r;
   assign ctl.rd    = rd_r;
   assign ctl.wr    = wr_r;
   assign ctl.rfsh  = rfsh_r;

endmodule

// File: doc/jtframe_bank_arb.md
Name: jtframe_bank_arb

Overview:
- Parametrised SDRAM request arbiter between game bank ports, the ROM-download (prog) port and a single-command SDRAM controller.
- Generalises the fixed four-bank hookup (bank 0 R/W, banks 1-3 read-only) to BANKS channels with a per-bank write-enable mask.
- Adds round-robin arbitration and idle-gated refresh.
- Sits inside the board layer between the game-facing baN_* ports and the SDRAM controller, all on clk_rom.

Parameters:
- BANKS, 4, number of game request channels (1..8).
- AW, 22, word address width per channel.
- WR_MASK, 4'b0001, bit n=1 lets bank n write; writes on other banks are ignored.

Ports:
- clk_rom  in  1  SDRAM clock, sole clock.
- rst  in  1  synchronous reset, active high.
- downloading  in  1  ROM download in progress; prog port owns the controller.
- prog_addr  in  AW  download word address.
- prog_ba  in  2  download target bank.
- prog_data  in  16  download write data.
- prog_mask  in  2  download byte mask, active low.
- prog_we  in  1  download write request.
- prog_rd  in  1  download read request.
- prog_ack  out  1  download command accepted.
- prog_rdy  out  1  download command complete.
- ba_addr  in  BANKS*AW  packed channel addresses, channel n at [n*AW+:AW].
- ba_rd  in  BANKS  read requests.
- ba_wr  in  BANKS  write requests.
- ba_din  in  BANKS*16  write data.
- ba_din_m  in  BANKS*2  byte masks, active low.
- ba_ack  out  BANKS  one-cycle accept pulse to the owning channel.
- ba_rdy  out  BANKS  one-cycle completion pulse to the owning channel.
- rfsh_en  in  1  game permits refresh.
- ctl_addr  out  AW  command address.
- ctl_ba  out  2  command bank.
- ctl_din  out  16  command write data.
- ctl_din_m  out  2  command byte mask.
- ctl_rd  out  1  read command request.
- ctl_wr  out  1  write command request.
- ctl_rfsh  out  1  refresh request.
- ctl_ack  in  1  controller accepted the command.
- ctl_rdy  in  1  controller finished the command; read data is valid on the shared sdram_dout, which is not routed through this block.

Behaviour:
- State machine IDLE -> ISSUE -> WAIT -> IDLE. One command outstanding at a time.
- Reset: state=IDLE; rr_ptr=0; all outputs 0, including ctl_* and all ack/rdy.
- IDLE, downloading=1, prog_we or prog_rd high: grant the prog port. ctl_ba=prog_ba, ctl_wr=prog_we, ctl_rd=prog_rd&~prog_we. Game requests receive no ack while downloading=1.
- IDLE, downloading=0: a request is a bank with ba_rd[n] set, or with ba_wr[n] set and WR_MASK[n]=1.
  - Round-robin search starts at rr_ptr; first requester wins.
  - ctl_ba=n[1:0]. Banks >=4 map modulo 4; the address carries the distinction.
  - Winner has both rd and wr with write permission: write wins. Without write permission, wr is ignored and rd is served.
- Grant, address, data and mask are registered. ctl_rd/ctl_wr assert the cycle after the request is first seen in IDLE, giving 1-cycle issue latency.
- ISSUE: hold all ctl_* stable until ctl_ack=1.
  - On that cycle, pulse the owner's ack for 1 cycle, deassert ctl_rd/ctl_wr, go to WAIT.
  - ctl_ack and ctl_rdy in the same cycle: pulse ack and rdy together and go directly to IDLE.
- WAIT: on ctl_rdy, pulse the owner's rdy for 1 cycle, set rr_ptr=(owner+1) mod BANKS (unchanged for prog), go to IDLE.
- Requests are not cancellable. If the requester drops rd/wr after grant, the command still completes and ack/rdy are still pulsed.
- Refresh: ctl_rfsh pulses for 1 cycle when state=IDLE, rfsh_en=1, no eligible request, and the previous cycle was not a refresh pulse. A request arriving in the same cycle beats refresh.
- downloading toggling mid-command: the current owner completes; the new mode applies from the next IDLE.
- rst mid-command: immediate return to reset values, no rdy pulsed. The controller shares rst.

Optional Feature:
- JTFRAME_BA_FIXPRIO_EN defined: fixed priority, lowest index wins; rr_ptr is not implemented.
- Undefined: round-robin as described under Behaviour.

Decomposition:
- Package jtframe_sdram_pkg: state enum (IDLE, ISSUE, WAIT) and the BA_W=2 constant.
- Sub-module jtframe_rr_pick: BANKS-wide request vector plus start pointer in, one-hot grant and index out; purely combinational.

Test Plan:
- Reset, then ba_rd=4'b0110, ctl_ack 2 cycles after issue, ctl_rdy 3 cycles later -> bank1 served first (ack then rdy); bank2 next; rr_ptr then 3.
- ba_wr[2]=1 only, WR_MASK=4'b0001 -> no ctl_wr ever; ba_ack[2] stays 0.
- downloading=1, prog_we=1, prog_addr=22'h12345, prog_ba=2, ba_rd[0]=1 -> ctl_wr=1, ctl_addr=22'h12345, ctl_ba=2; ba_ack[0] held 0 until downloading=0.
- Idle, rfsh_en=1, no requests for 4 cycles -> ctl_rfsh pulses on alternate cycles; same cycle as ba_rd[3] rising -> the read wins.
- ba_rd[0] dropped right after ba_ack[0] -> ba_rdy[0] still pulses on ctl_rdy.
- rst asserted in WAIT -> next cycle all outputs 0 and state IDLE; the following ctl_rdy is ignored.
